// File: rtl/game_pkg.sv
// Shared constants for the duck-hunt style game datapath.
// Holds screen geometry, sprite sizing, colours, FSM state codes and small saturating helpers.
package game_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int SPR          = 8;
    localparam int STEP         = 2;
    localparam int ESCAPE_TICKS = 10;
    localparam int AMMO         = 3;

    // Largest legal sprite origin on each axis
    localparam logic [7:0] MAX_X = 8'(SCREEN_W - SPR);
    localparam logic [6:0] MAX_Y = 7'(SCREEN_H - SPR);

    // Reset / respawn positions
    localparam logic [7:0] CROSS_X0 = 8'd76;
    localparam logic [6:0] CROSS_Y0 = 7'd56;
    localparam logic [7:0] BIRD_X0  = 8'd0;
    localparam logic [6:0] BIRD_Y0  = 7'd100;

    localparam logic [2:0] BG_COL    = 3'b011;
    localparam logic [2:0] CROSS_COL = 3'b111;
    localparam logic [2:0] BIRD_COL  = 3'b100;

    typedef enum logic [3:0] {
        ST_HOLD    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_RIGHT   = 4'd2,
        ST_LEFT    = 4'd3,
        ST_PREHOLD = 4'd4,
        ST_DRAW    = 4'd5,
        ST_DOWN    = 4'd6,
        ST_UP      = 4'd7,
        ST_IS_SHOT = 4'd10
    } state_t;

    // Step up by STEP, clamping at lim
    function automatic logic [7:0] add_sat(input logic [7:0] v,
                                           input logic [7:0] lim);
        return (v > lim - 8'(STEP)) ? lim : v + 8'(STEP);
    endfunction

    // Step down by STEP, clamping at zero
    function automatic logic [7:0] sub_sat(input logic [7:0] v);
        return (v < 8'(STEP)) ? 8'd0 : v - 8'(STEP);
    endfunction

endpackage

// File: rtl/sprite_sweeper.sv
// Walks an SPR x SPR pixel block row-major, one pixel per cycle, from a latched origin.
// Ports: clk, reset_n, start, org_x/org_y/colour (sampled on start), vga_* pixel bus, sweep_done.
module sprite_sweeper
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       sweep_done
);

    localparam logic [2:0] LAST = 3'(SPR - 1);

    logic [2:0] cx;
    logic [2:0] cy;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [2:0] col;
    logic       active;

    // A start while active simply restarts from the new origin (abort)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cx         <= '0;
            cy         <= '0;
            ox         <= '0;
            oy         <= '0;
            col        <= '0;
            active     <= 1'b0;
            sweep_done <= 1'b1;
        end else if (start) begin
            cx         <= '0;
            cy         <= '0;
            ox         <= org_x;
            oy         <= org_y;
            col        <= colour;
            active     <= 1'b1;
            sweep_done <= 1'b0;
        end else if (active) begin
            cx <= cx + 3'd1;
            if (cx == LAST) begin
                cy <= cy + 3'd1;
                if (cy == LAST) begin
                    active     <= 1'b0;
                    sweep_done <= 1'b1;
                end
            end
        end
    end

    assign vga_x      = ox + {5'd0, cx};
    assign vga_y      = oy + {4'd0, cy};
    assign vga_colour = col;
    assign vga_plot   = active;

endmodule

// File: rtl/sprite_position_datapath.sv
// Datapath behind the movement FSM: moves crosshair/bird, redraws sprites, tracks game events.
// Ports: clk/reset_n, state_i/porb_i/fire_i/tick_i/rand_x_i in; vga_* bus, done_drawing and event levels out.
module sprite_position_datapath
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] state_i,
    input  logic       porb_i,
    input  logic       fire_i,
    input  logic       tick_i,
    input  logic [7:0] rand_x_i,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       done_drawing,
    output logic       is_shot,
    output logic       escape,
    output logic       leave,
    output logic       out_of_ammo
);

    logic [7:0] cross_x;
    logic [6:0] cross_y;
    logic [7:0] bird_x;
    logic [6:0] bird_y;
    logic [1:0] ammo;
    logic [3:0] timer;
    logic       fire_q;
    logic [3:0] prev_state;
    logic       prev_porb;

    logic       is_sweep_state;
    logic       start;
    logic       sweep_done;
    logic [7:0] org_x;
    logic [6:0] org_y;
    logic [2:0] colour;

    logic       fire_edge;
    logic       respawn;
    logic       shoot;
    logic [7:0] cen_x;
    logic [6:0] cen_y;
    logic       hit;
    logic       hit_now;
    logic       tick_live;
    logic       esc_now;
    logic [7:0] spawn_x;

    // Sweep start: entering CLEAR/DRAW or switching the selected object
    assign is_sweep_state = (state_i == ST_CLEAR) || (state_i == ST_DRAW);
    assign start = is_sweep_state &&
                   ((state_i != prev_state) || (porb_i != prev_porb));

    assign org_x  = porb_i ? bird_x : cross_x;
    assign org_y  = porb_i ? bird_y : cross_y;
    assign colour = (state_i == ST_CLEAR) ? BG_COL :
                    (porb_i ? BIRD_COL : CROSS_COL);

    sprite_sweeper u_sweeper (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .org_x      (org_x),
        .org_y      (org_y),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .sweep_done (sweep_done)
    );

    // Mask done in the start cycle so the FSM never sees the previous sweep's done
    assign done_drawing = sweep_done & ~start;

    assign fire_edge = fire_i & ~fire_q;
    assign respawn   = (state_i == ST_IS_SHOT) && leave;
    assign shoot     = fire_edge && (ammo != 2'd0) && !respawn;

    // Crosshair centre inside the bird box
    assign cen_x = cross_x + 8'(SPR / 2);
    assign cen_y = cross_y + 7'(SPR / 2);
    assign hit   = (cen_x >= bird_x) && (cen_x < bird_x + 8'(SPR)) &&
                   (cen_y >= bird_y) && (cen_y < bird_y + 7'(SPR));
    assign hit_now = shoot && hit;

    // A hit in the same cycle beats an escape
    assign tick_live = tick_i && !is_shot && !escape && !respawn;
    assign esc_now   = tick_live && !hit_now &&
                       ((timer == 4'(ESCAPE_TICKS - 1)) || (ammo == 2'd0));

    assign spawn_x = (rand_x_i >= MAX_X) ? rand_x_i - MAX_X : rand_x_i;

    assign out_of_ammo = (ammo == 2'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cross_x    <= CROSS_X0;
            cross_y    <= CROSS_Y0;
            bird_x     <= BIRD_X0;
            bird_y     <= BIRD_Y0;
            ammo       <= 2'(AMMO);
            timer      <= '0;
            is_shot    <= 1'b0;
            escape     <= 1'b0;
            leave      <= 1'b0;
            fire_q     <= 1'b0;
            prev_state <= ST_CLEAR;
            prev_porb  <= 1'b0;
        end else begin
            fire_q     <= fire_i;
            prev_state <= state_i;
            prev_porb  <= porb_i;
            if (respawn) begin
                is_shot <= 1'b0;
                escape  <= 1'b0;
                leave   <= 1'b0;
                timer   <= '0;
                ammo    <= 2'(AMMO);
                bird_x  <= spawn_x;
                bird_y  <= BIRD_Y0;
            end else begin
                if (shoot) begin
                    ammo <= ammo - 2'd1;
                end
                if (hit_now) begin
                    is_shot <= 1'b1;
                end
                if (tick_live) begin
                    timer <= timer + 4'd1;
                end
                if (esc_now) begin
                    escape <= 1'b1;
                end
                case (state_i)
                    ST_RIGHT: begin
                        if (porb_i) begin
                            bird_x <= add_sat(bird_x, MAX_X);
                        end else begin
                            cross_x <= add_sat(cross_x, MAX_X);
                        end
                    end
                    ST_LEFT: begin
                        if (porb_i) begin
                            bird_x <= sub_sat(bird_x);
                        end else begin
                            cross_x <= sub_sat(cross_x);
                        end
                    end
                    ST_DOWN: begin
                        if (porb_i) begin
                            bird_y <= 7'(add_sat({1'b0, bird_y}, {1'b0, MAX_Y}));
                            if (bird_y > MAX_Y - 7'(STEP)) begin
                                leave <= 1'b1;
                            end
                        end else begin
                            cross_y <= 7'(add_sat({1'b0, cross_y}, {1'b0, MAX_Y}));
                        end
                    end
                    ST_UP: begin
                        if (porb_i) begin
                            bird_y <= 7'(sub_sat({1'b0, bird_y}));
                            if (bird_y < 7'(STEP)) begin
                                leave <= 1'b1;
                            end
                        end else begin
                            cross_y <= 7'(sub_sat({1'b0, cross_y}));
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
